fifo_uart_tx: RTL

Downstream drain stage for the 32-deep byte FIFO. It watches the FIFO `empty` flag and pops one byte at a time with a single-cycle `rd` pulse. It captures the registered `rd_data` and serialises the byte onto a UART line as 8N1, LSB first. It sits between the FIFO read port and the chip-level serial pin.

---
 rtl/fifo_uart_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and serialises it as 8N1 (LSB first) on tx.
// Optional even parity bit between data and stop when PARITY_TX_EN is defined.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] rd_data,
  output logic       rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
`ifdef PARITY_TX_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [7:0]      shreg;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic            baud_end;
`ifdef PARITY_TX_EN
  logic            par;
`endif

  always_comb begin
    baud_end = (baud_cnt == BAUD_LAST);
  end

  // Outputs are registered alongside the state, so each is set on the edge
  // that enters the state it belongs to.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      rd         <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef PARITY_TX_EN
      par        <= 1'b0;
`endif
    end else begin
      rd         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx       <= 1'b1;
          if (!empty) begin
            state <= FETCH;
            rd    <= 1'b1;
            busy  <= 1'b1;
          end
        end

        FETCH: begin
          state <= LOAD;
        end

        LOAD: begin
          shreg    <= rd_data;
`ifdef PARITY_TX_EN
          par      <= ^rd_data;
`endif
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef PARITY_TX_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

`ifdef PARITY_TX_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
`endif

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
            // registered pulse lands in the final stop cycle
            if (baud_cnt == BAUD_PRE) begin
              frame_done <= 1'b1;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
